// File: rtl/bakery_pkg.sv
// Shared types and constants for the bakery mutual-exclusion model.
package bakery_pkg;

  // Program locations of one bakery process; L1 encodes as zero.
  typedef enum logic [3:0] {
    L1, L2, L3, L4, L5, L6, L7, L8, L9, L10, L11, L12
  } loc;

  localparam int unsigned MODE_CLASSIC = 0;
  localparam int unsigned MODE_BW      = 1;

endpackage

// File: rtl/bakery_tkmax.sv
// Colour-filtered maximum over all tickets, producing the next ticket value
// with saturation instead of wrap.
module bakery_tkmax
  import bakery_pkg::*;
#(
  parameter int unsigned TKMSB  = 2,
  parameter int unsigned HIPROC = 1,
  parameter int unsigned MODE   = MODE_BW
) (
  input  logic [HIPROC:0][TKMSB:0] tickets,
  input  logic [HIPROC:0]          mycolors,
  input  logic                     pcolor,
  output logic [TKMSB:0]           next_ticket,
  output logic                     sat
);

  localparam int unsigned TW = TKMSB + 1;
  localparam int unsigned NP = HIPROC + 1;

  logic [TW-1:0] m;

  // Max over processes sharing p's colour (all processes in classic mode).
  always_comb begin
    m = '0;
    for (int unsigned q = 0; q < NP; q++) begin
      if ((MODE == MODE_CLASSIC || mycolors[q] == pcolor) && tickets[q] > m) begin
        m = tickets[q];
      end
    end
  end

  assign sat         = &m;
  assign next_ticket = sat ? m : m + TW'(1);

endmodule

// File: rtl/bakery_bw.sv
// Bakery / black-white bakery mutual-exclusion model: one process chosen by
// select advances one location per clock.
module bakery_bw
  import bakery_pkg::*;
#(
  parameter int unsigned TKMSB  = 2,
  parameter int unsigned HIPROC = 1,
  parameter int unsigned SELMSB = 1,
  parameter int unsigned MODE   = MODE_BW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [SELMSB:0] select,
  input  logic            pause,
  output logic [HIPROC:0] in_cs,
  output logic            color,
  output logic            mutex_err,
  output logic            tk_ovf
);

  localparam int unsigned TW = TKMSB + 1;
  localparam int unsigned SW = SELMSB + 1;
  localparam int unsigned NP = HIPROC + 1;
  localparam logic [SW-1:0] HI = SW'(HIPROC);
  localparam bit BW       = (MODE == MODE_BW);
  localparam bit OVF_FREE = BW && (TW >= $clog2(HIPROC + 2));

  loc                   pc [NP];
  logic [NP-1:0][TW-1:0] ticket;
  logic [NP-1:0]        choosing;
  logic [NP-1:0]        mycolor;
  logic [SW-1:0]        j [NP];
  logic [SW-1:0]        k;
  logic [SW-1:0]        sel_reg;

  logic [SW-1:0] sel;
  logic [SW-1:0] j_p;
  loc            cur_loc;
  loc            nxt_loc;
  logic          myc_p;
  logic [TW-1:0] tk_p;
  logic          ch_k;
  logic          col_k;
  logic [TW-1:0] tk_k;
  logic          blocked;
  logic [TW-1:0] next_ticket;
  logic          sat;

  // Out-of-range selections fall back to process 0.
  always_comb begin
    sel = (select > HI) ? '0 : select;
  end

  // Gather the selected process p and the process k = j[p] it is examining.
  always_comb begin
    cur_loc = L1;
    myc_p   = 1'b0;
    tk_p    = '0;
    j_p     = '0;
    ch_k    = 1'b0;
    col_k   = 1'b0;
    tk_k    = '0;
    for (int unsigned q = 0; q < NP; q++) begin
      if (sel == SW'(q)) begin
        cur_loc = pc[q];
        myc_p   = mycolor[q];
        tk_p    = ticket[q];
        j_p     = j[q];
      end
    end
    for (int unsigned q = 0; q < NP; q++) begin
      if (j_p == SW'(q)) begin
        ch_k  = choosing[q];
        col_k = mycolor[q];
        tk_k  = ticket[q];
      end
    end
  end

  // L8 wait condition; ties resolved in favour of the lower index.
  always_comb begin
    blocked = 1'b0;
    if (!BW || col_k == myc_p) begin
      blocked = (tk_k != '0) && (col_k == myc_p) &&
                ((tk_k < tk_p) || ((tk_k == tk_p) && (j_p < sel)));
    end else begin
      blocked = (tk_k != '0) && (myc_p == color) && (col_k != myc_p);
    end
  end

  // Next location of the selected process.
  always_comb begin
    nxt_loc = L1;
    case (cur_loc)
      L1:      nxt_loc = L2;
      L2:      nxt_loc = L3;
      L3:      nxt_loc = L4;
      L4:      nxt_loc = L5;
      L5:      nxt_loc = L6;
      L6:      nxt_loc = (j_p <= HI) ? L7 : L10;
      L7:      nxt_loc = ch_k ? L7 : L8;
      L8:      nxt_loc = blocked ? L8 : L9;
      L9:      nxt_loc = L6;
      L10:     nxt_loc = pause ? L10 : L11;
      L11:     nxt_loc = L12;
      L12:     nxt_loc = pause ? L12 : L1;
      default: nxt_loc = L1;
    endcase
  end

  bakery_tkmax #(
    .TKMSB (TKMSB),
    .HIPROC(HIPROC),
    .MODE  (MODE)
  ) u_tkmax (
    .tickets    (ticket),
    .mycolors   (mycolor),
    .pcolor     (myc_p),
    .next_ticket(next_ticket),
    .sat        (sat)
  );

  // All model state: reset, per-location side effects of p, and output flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned q = 0; q < NP; q++) begin
        pc[q] <= L1;
        j[q]  <= '0;
      end
      ticket    <= '0;
      choosing  <= '0;
      mycolor   <= '0;
      k         <= '0;
      sel_reg   <= '0;
      color     <= 1'b0;
      in_cs     <= '0;
      mutex_err <= 1'b0;
      tk_ovf    <= 1'b0;
    end else begin
      sel_reg   <= sel;
      mutex_err <= mutex_err | ((in_cs & (in_cs - NP'(1))) != '0);
      for (int unsigned q = 0; q < NP; q++) begin
        in_cs[q] <= (((sel == SW'(q)) ? nxt_loc : pc[q]) == L10);
        if (sel == SW'(q)) begin
          pc[q] <= nxt_loc;
          case (pc[q])
            L1: choosing[q] <= 1'b1;
            L2: if (BW) mycolor[q] <= color;
            L3: begin
              ticket[q] <= next_ticket;
              if (sat) tk_ovf <= 1'b1;
            end
            L4: choosing[q] <= 1'b0;
            L5: j[q] <= '0;
            L7, L8: k <= j[q];
            L9: j[q] <= j[q] + SW'(1);
            L11: begin
              if (BW) color <= ~mycolor[q];
              ticket[q] <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Model invariants: indices stay in range; wide-enough BW tickets never saturate.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (sel_reg <= HI);
      assert (k <= HI);
      if (OVF_FREE) assert (!tk_ovf);
    end
  end

endmodule

// File: tb/tb_bakery_bw.sv
// Directed and random checks of bakery_bw in three parameter configurations.
module tb_bakery_bw;
  import bakery_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_a, rst_b, rst_c;
  logic [1:0] sel_a, sel_b, sel_c;
  logic       pause_a, pause_b, pause_c;
  logic [1:0] cs_a, cs_b;
  logic [2:0] cs_c;
  logic       col_a, col_b, col_c;
  logic       mx_a, mx_b, mx_c;
  logic       ov_a, ov_b, ov_c;

  // A: default black-white, B: classic with 2-bit tickets, C: 3-process black-white.
  bakery_bw #(.TKMSB(2), .HIPROC(1), .SELMSB(1), .MODE(1)) dut_a (
    .clock(clock), .reset(rst_a), .select(sel_a), .pause(pause_a),
    .in_cs(cs_a), .color(col_a), .mutex_err(mx_a), .tk_ovf(ov_a));
  bakery_bw #(.TKMSB(1), .HIPROC(1), .SELMSB(1), .MODE(0)) dut_b (
    .clock(clock), .reset(rst_b), .select(sel_b), .pause(pause_b),
    .in_cs(cs_b), .color(col_b), .mutex_err(mx_b), .tk_ovf(ov_b));
  bakery_bw #(.TKMSB(1), .HIPROC(2), .SELMSB(1), .MODE(1)) dut_c (
    .clock(clock), .reset(rst_c), .select(sel_c), .pause(pause_c),
    .in_cs(cs_c), .color(col_c), .mutex_err(mx_c), .tk_ovf(ov_c));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] sel;
    logic       pause;
    logic [1:0] cs;
    logic       col;
    logic [2:0] tk0;
  } vec_t;

  vec_t solo [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_b(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      sel_b = s;
      tick();
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, " in_cs"}, 32'(cs_a), 32'd0);
    chk({tag, " color"}, 32'(col_a), 32'd0);
    chk({tag, " mutex_err"}, 32'(mx_a), 32'd0);
    chk({tag, " tk_ovf"}, 32'(ov_a), 32'd0);
    for (int q = 0; q < 2; q++) begin
      chk($sformatf("%s pc%0d", tag, q), 32'(dut_a.pc[q]), 32'(L1));
      chk($sformatf("%s ticket%0d", tag, q), 32'(dut_a.ticket[q]), 32'd0);
    end
  endtask

  initial begin
    int cs_cycles;

    // Solo run of process 0: expected state after each edge.
    solo[0]  = '{2'd0, 1'b0, 2'b00, 1'b0, 3'd0};  // L2
    solo[1]  = '{2'd0, 1'b0, 2'b00, 1'b0, 3'd0};  // L3
    solo[2]  = '{2'd0, 1'b0, 2'b00, 1'b0, 3'd1};  // L4, ticket taken
    solo[3]  = '{2'd0, 1'b0, 2'b00, 1'b0, 3'd1};  // L5
    solo[4]  = '{2'd0, 1'b0, 2'b00, 1'b0, 3'd1};  // L6
    solo[5]  = '{2'd0, 1'b0, 2'b00, 1'b0, 3'd1};  // L7 j=0
    solo[6]  = '{2'd0, 1'b0, 2'b00, 1'b0, 3'd1};  // L8
    solo[7]  = '{2'd0, 1'b0, 2'b00, 1'b0, 3'd1};  // L9
    solo[8]  = '{2'd0, 1'b0, 2'b00, 1'b0, 3'd1};  // L6 j=1
    solo[9]  = '{2'd0, 1'b0, 2'b00, 1'b0, 3'd1};  // L7
    solo[10] = '{2'd0, 1'b0, 2'b00, 1'b0, 3'd1};  // L8
    solo[11] = '{2'd0, 1'b0, 2'b00, 1'b0, 3'd1};  // L9
    solo[12] = '{2'd0, 1'b0, 2'b00, 1'b0, 3'd1};  // L6 j=2
    solo[13] = '{2'd0, 1'b0, 2'b01, 1'b0, 3'd1};  // L10 critical section
    solo[14] = '{2'd0, 1'b0, 2'b00, 1'b0, 3'd1};  // L11
    solo[15] = '{2'd0, 1'b0, 2'b00, 1'b1, 3'd0};  // L12, ticket freed, colour flipped

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    sel_a = '0; sel_b = '0; sel_c = '0;
    pause_a = 1'b0; pause_b = 1'b0; pause_c = 1'b0;
    tick();
    tick();

    // Solo trace with select=0, then with out-of-range select=3.
    for (int pass = 0; pass < 2; pass++) begin
      rst_a = 1'b1;
      tick();
      chk_reset_a($sformatf("reset%0d", pass));
      rst_a = 1'b0;
      for (int i = 0; i < 16; i++) begin
        sel_a   = (pass == 1) ? 2'd3 : solo[i].sel;
        pause_a = solo[i].pause;
        tick();
        chk($sformatf("solo%0d e%0d in_cs", pass, i + 1), 32'(cs_a), 32'(solo[i].cs));
        chk($sformatf("solo%0d e%0d color", pass, i + 1), 32'(col_a), 32'(solo[i].col));
        chk($sformatf("solo%0d e%0d ticket0", pass, i + 1), 32'(dut_a.ticket[0]), 32'(solo[i].tk0));
      end
      chk($sformatf("solo%0d mutex_err", pass), 32'(mx_a), 32'd0);
    end

    // Pause inside the critical section, then reset wins over the step.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    sel_a = 2'd0;
    pause_a = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("pause enter in_cs", 32'(cs_a), 32'b01);
    pause_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("pause hold%0d in_cs", i), 32'(cs_a), 32'b01);
    end
    rst_a = 1'b1;
    tick();
    chk("pause reset in_cs", 32'(cs_a), 32'd0);
    chk("pause reset pc0", 32'(dut_a.pc[0]), 32'(L1));
    chk("pause reset ticket0", 32'(dut_a.ticket[0]), 32'd0);

    // Classic mode, 2-bit tickets: drive tickets to 3 and 3, saturating once.
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    run_b(2'd0, 3);
    chk("ovf t0 first", 32'(dut_b.ticket[0]), 32'd1);
    run_b(2'd1, 4);
    chk("ovf t1 first", 32'(dut_b.ticket[1]), 32'd2);
    run_b(2'd0, 11);
    chk("ovf p0 in_cs", 32'(cs_b), 32'b01);
    run_b(2'd0, 6);
    chk("ovf t0 second", 32'(dut_b.ticket[0]), 32'd3);
    chk("ovf no sat at m=2", 32'(ov_b), 32'd0);
    run_b(2'd0, 1);
    run_b(2'd1, 10);
    chk("ovf p1 in_cs", 32'(cs_b), 32'b10);
    run_b(2'd1, 6);
    chk("ovf t1 saturated", 32'(dut_b.ticket[1]), 32'd3);
    chk("ovf t0 held", 32'(dut_b.ticket[0]), 32'd3);
    chk("ovf flag set", 32'(ov_b), 32'd1);
    run_b(2'd0, 6);
    chk("ovf flag sticky", 32'(ov_b), 32'd1);
    chk("ovf color classic", 32'(col_b), 32'd0);
    chk("ovf mutex_err", 32'(mx_b), 32'd0);
    rst_b = 1'b1;
    tick();
    chk("ovf reset clears", 32'(ov_b), 32'd0);

    // Random schedule on three black-white processes with 2-bit tickets.
    rst_c = 1'b1;
    tick();
    rst_c = 1'b0;
    cs_cycles = 0;
    for (int cyc = 1; cyc <= 20000; cyc++) begin
      sel_c   = 2'($urandom_range(0, 3));
      pause_c = 1'($urandom_range(0, 1));
      tick();
      if (cs_c != 3'b000) cs_cycles++;
      if (cyc % 1000 == 0) begin
        chk($sformatf("rand c%0d mutex_err", cyc), 32'(mx_c), 32'd0);
        chk($sformatf("rand c%0d in_cs onehot", cyc), 32'($onehot0(cs_c)), 32'd1);
      end
    end
    chk("rand tk_ovf", 32'(ov_c), 32'd0);
    chk("rand progress", 32'(cs_cycles > 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
